result_display_driver: RTL and testbench
========================================

// Module: result_display_driver
// PURPOSE
//  Downstream of the 3-bit sign-magnitude adder/subtractor: captures its 5-bit
//  result {sign, mag[3:0]} and zeroflag on a load strobe, then drives a
//  time-multiplexed 3-digit 7-segment display: sign, tens, ones.
//  Flags inconsistent zeroflag/result pairs. Sits between the arithmetic core
//  and the board pins.
// PARAMETERS
//  TICK_DIV  50000  clk cycles per digit slot; legal range >= 2
// PORTS
//  clk       in   1  system clock, rising edge
//  rst_n     in   1  reset, asynchronous, active-low
//  result    in   5  [4]=sign (1=neg), [3:0]=magnitude 0..15
//  zeroflag  in   1  1 when result magnitude is zero
//  load      in   1  capture strobe, sampled on rising clk edge
//  seg       out  7  {g,f,e,d,c,b,a}, active-low, registered
//  an        out  3  digit enables, active-low, one-hot-low; [0]=ones [1]=tens [2]=sign
//  err       out  1  registered; 1 = last capture was inconsistent
// BEHAVIOUR
//  Reset (async, rst_n=0): seg=7'h7F, an=3'b111, err=0, prescaler=0,
//   digit_idx=0, captured=0. Takes effect immediately, mid-scan included.
//  Capture: on an edge with load=1, register sign, mag, zf; set captured=1.
//   load held high re-captures every cycle. The last edge wins.
//  Normalisation: sign=1 & mag=0 (negative zero) is shown as "0" with no minus.
//   Not an error.
//  Consistency: err is set when zf != (mag==0), evaluated at capture.
//   err is cleared by the next consistent capture.
//  Prescaler: counts 0..TICK_DIV-1. tick=1 in the cycle the count equals
//   TICK_DIV-1; the count then wraps to 0.
//   On tick, digit_idx advances 0->1->2->0. Any other value goes to 0.
//  Anti-ghost: in the cycle after tick, an=3'b111 and seg=7'h7F.
//   Otherwise an drives only the digit_idx position low.
//  Digit content (captured=1, err=0):
//   ones  = decode(mag>=10 ? mag-10 : mag)
//   tens  = mag>=10 ? decode(1) : blank (leading-zero suppression)
//   sign  = (sign & mag!=0) ? MINUS (g only, 7'b0111111) : blank
//  err=1: ones="E" (7'b0000110); tens and sign are blank.
//  captured=0: all digits blank; the scan still runs.
//  Latency: load edge N gives captured regs at N.
//   seg/an reflect the new value at edge N+1 if that digit is active.
//  load coinciding with tick: capture and digit advance both happen.
//   The new digit shows the new value one cycle later.
// STRUCTURE
//  Shared package display_pkg:
//   - SEG_BLANK, SEG_MINUS, SEG_E constants
//   - 0..9 segment table
//   - DIG_ONES/DIG_TENS/DIG_SIGN index constants
//   - SEG_W=7 and AN_W=3 widths
//  Sub-module seg7_decoder: combinational, 4-bit digit in, 7-bit active-low
//   segments out; 10..15 map to blank.
//  Top module holds: prescaler, digit_idx counter, capture regs, err logic,
//   output registers.
// TESTING  (bench uses TICK_DIV=4)
//  T1 reset: rst_n=0 between edges -> seg=7F, an=111, err=0 without clock.
//     After release, no load for 20 cycles -> seg stays 7F.
//  T2 result=5'b1_0110, zf=0, load 1 cycle -> scan shows:
//     ones an=110 seg=0000010; tens an=101 seg=7F; sign an=011 seg=0111111.
//  T3 result=5'b0_1100, zf=0 -> ones seg=0100100 ("2"), tens seg=1111001 ("1"),
//     sign 7F.
//  T4 result=5'b1_0000, zf=1 -> ones seg=1000000, tens 7F, sign 7F, err=0.
//  T5 result=5'b0_0011, zf=1 -> err=1, ones seg=0000110 ("E").
//     Then load 5'b0_0011, zf=0 -> err=0, ones seg=0110000 ("3").
//  T6 load asserted in the tick cycle; rst_n pulsed mid-slot.
//     Check blank guard cycle, correct new digit, immediate async clear.
//  Every cycle: at most one an bit low; an=111 in each post-tick cycle.

Source files
------------

// File: rtl/result_display_driver_pkg.sv
// Shared constants for the result display: segment encodings (active-low {g,f,e,d,c,b,a}),
// digit slot indices and the slot-to-anode mapping.
package display_pkg;

    localparam int SEG_W = 7;
    localparam int AN_W  = 3;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;

    // Entry d of this packed table is the glyph for decimal digit d.
    localparam logic [9:0][SEG_W-1:0] SEG_TABLE = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    localparam logic [1:0] DIG_ONES = 2'd0;
    localparam logic [1:0] DIG_TENS = 2'd1;
    localparam logic [1:0] DIG_SIGN = 2'd2;

    typedef logic [1:0] digit_idx_t;

    function automatic logic [AN_W-1:0] an_for_digit(input digit_idx_t idx);
        logic [AN_W-1:0] an;
        an = 3'b111;
        case (idx)
            DIG_ONES: an = 3'b110;
            DIG_TENS: an = 3'b101;
            DIG_SIGN: an = 3'b011;
            default:  an = 3'b111;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/result_display_driver_if.sv
// Bundle between the arithmetic core (master side) and the display driver (slave side).
interface result_display_driver_if
    import display_pkg::*;
();

    logic [4:0]       result;
    logic             zeroflag;
    logic             load;
    logic [SEG_W-1:0] seg;
    logic [AN_W-1:0]  an;
    logic             err;

    modport master (output result, zeroflag, load, input seg, an, err);
    modport slave  (input result, zeroflag, load, output seg, an, err);

endinterface

// File: rtl/result_display_driver_seg7_decoder.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 are blank.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0]       i_digit,
    output logic [SEG_W-1:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (i_digit <= 4'd9) begin
            o_seg = SEG_TABLE[i_digit];
        end
    end

endmodule

// File: rtl/result_display_driver.sv
// Captures a sign-magnitude result and scans it onto a 3-digit multiplexed
// 7-segment display (sign, tens, ones) with a blank guard cycle after every slot change.
module result_display_driver
    import display_pkg::*;
#(
    parameter int TICK_DIV = 50000
)(
    input  logic                   clk,
    input  logic                   rst_n,
    result_display_driver_if.slave disp_if
);

    localparam int            PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]    r_presc;
    digit_idx_t       r_digit_idx;
    logic             r_sign;
    logic [3:0]       r_mag;
    logic             r_captured;
    logic             r_err;
    logic [SEG_W-1:0] r_seg;
    logic [AN_W-1:0]  r_an;

    logic             w_tick;
    logic             w_mag_ge10;
    logic [3:0]       w_ones_digit;
    logic [SEG_W-1:0] w_ones_seg;
    logic [SEG_W-1:0] w_digit_seg;
    logic             w_negative;

    assign w_tick       = (r_presc == LAST);
    assign w_mag_ge10   = (r_mag >= 4'd10);
    assign w_ones_digit = w_mag_ge10 ? (r_mag - 4'd10) : r_mag;
    // Negative zero is displayed without a minus sign.
    assign w_negative   = r_sign & (r_mag != 4'd0);

    seg7_decoder u_ones_dec (
        .i_digit (w_ones_digit),
        .o_seg   (w_ones_seg)
    );

    always_comb begin
        w_digit_seg = SEG_BLANK;
        if (r_captured) begin
            if (r_err) begin
                if (r_digit_idx == DIG_ONES) begin
                    w_digit_seg = SEG_E;
                end
            end else begin
                case (r_digit_idx)
                    DIG_ONES: w_digit_seg = w_ones_seg;
                    DIG_TENS: w_digit_seg = w_mag_ge10 ? SEG_TABLE[1] : SEG_BLANK;
                    DIG_SIGN: w_digit_seg = w_negative ? SEG_MINUS : SEG_BLANK;
                    default:  w_digit_seg = SEG_BLANK;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc     <= '0;
            r_digit_idx <= DIG_ONES;
        end else if (w_tick) begin
            r_presc <= '0;
            case (r_digit_idx)
                DIG_ONES: r_digit_idx <= DIG_TENS;
                DIG_TENS: r_digit_idx <= DIG_SIGN;
                default:  r_digit_idx <= DIG_ONES;
            endcase
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign     <= 1'b0;
            r_mag      <= 4'd0;
            r_captured <= 1'b0;
            r_err      <= 1'b0;
        end else if (disp_if.load) begin
            r_sign     <= disp_if.result[4];
            r_mag      <= disp_if.result[3:0];
            r_captured <= 1'b1;
            r_err      <= disp_if.zeroflag != (disp_if.result[3:0] == 4'd0);
        end
    end

    // Tick edge loads a blank frame so the old digit never lights under the new anode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_BLANK;
            r_an  <= 3'b111;
        end else if (w_tick) begin
            r_seg <= SEG_BLANK;
            r_an  <= 3'b111;
        end else begin
            r_seg <= w_digit_seg;
            r_an  <= an_for_digit(r_digit_idx);
        end
    end

    assign disp_if.seg = r_seg;
    assign disp_if.an  = r_an;
    assign disp_if.err = r_err;

endmodule

// File: tb/tb_result_display_driver.sv
// Directed self-checking bench for result_display_driver with a 4-cycle digit slot.
module tb_result_display_driver;

    logic clk;
    logic rst_n;
    int   assertCount;
    int   failCount;

    int         mPresc;
    logic [1:0] mIdx;
    logic       mTickD;
    logic       mValid;

    logic [6:0] expSeg [3];
    logic [1:0] newIdx;
    bit         tickFound;

    result_display_driver_if dispIf ();

    result_display_driver #(.TICK_DIV(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .disp_if (dispIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [2:0] expAn(input logic [1:0] idx);
        case (idx)
            2'd0:    return 3'b110;
            2'd1:    return 3'b101;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // Reference scan timing: slot counter and the guard cycle that follows every tick.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPresc <= 0;
            mIdx   <= 2'd0;
            mTickD <= 1'b0;
            mValid <= 1'b0;
        end else begin
            mValid <= 1'b1;
            mTickD <= (mPresc == 3);
            if (mPresc == 3) begin
                mPresc <= 0;
                mIdx   <= (mIdx == 2'd2) ? 2'd0 : mIdx + 2'd1;
            end else begin
                mPresc <= mPresc + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && mValid) begin
            if (mTickD) begin
                checkOutput("guardAn", 32'(dispIf.an), 32'(3'b111));
                checkOutput("guardSeg", 32'(dispIf.seg), 32'(7'h7F));
            end else begin
                checkOutput("scanAn", 32'(dispIf.an), 32'(expAn(mIdx)));
            end
            checkOutput("oneHot", 32'($countones(~dispIf.an) <= 1), 32'd1);
        end
    end

    task automatic applyStimulus(input logic [4:0] res, input logic zf);
        @(negedge clk);
        dispIf.result   = res;
        dispIf.zeroflag = zf;
        dispIf.load     = 1'b1;
        @(negedge clk);
        dispIf.load     = 1'b0;
    endtask

    task automatic waitDigit(input string tag, input logic [2:0] anPat, input logic [6:0] segExp);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (dispIf.an === anPat) found = 1'b1;
        end
        checkOutput({tag, "Found"}, 32'(found), 32'd1);
        if (found) checkOutput(tag, 32'(dispIf.seg), 32'(segExp));
    endtask

    initial begin
        assertCount     = 0;
        failCount       = 0;
        dispIf.result   = 5'd0;
        dispIf.zeroflag = 1'b0;
        dispIf.load     = 1'b0;
        rst_n           = 1'b0;

        // T1: reset state, idle scan, then asynchronous reset between edges
        repeat (2) @(negedge clk);
        checkOutput("t1RstSeg", 32'(dispIf.seg), 32'(7'h7F));
        checkOutput("t1RstAn", 32'(dispIf.an), 32'(3'b111));
        checkOutput("t1RstErr", 32'(dispIf.err), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("t1IdleSeg", 32'(dispIf.seg), 32'(7'h7F));
        end
        applyStimulus(5'b0_0011, 1'b1);
        checkOutput("t1PreErr", 32'(dispIf.err), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t1AsyncAn", 32'(dispIf.an), 32'(3'b111));
        checkOutput("t1AsyncSeg", 32'(dispIf.seg), 32'(7'h7F));
        checkOutput("t1AsyncErr", 32'(dispIf.err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T2: -6
        applyStimulus(5'b1_0110, 1'b0);
        checkOutput("t2Err", 32'(dispIf.err), 32'd0);
        waitDigit("t2Ones", 3'b110, 7'b0000010);
        waitDigit("t2Tens", 3'b101, 7'h7F);
        waitDigit("t2Sign", 3'b011, 7'b0111111);

        // T3: +12
        applyStimulus(5'b0_1100, 1'b0);
        waitDigit("t3Ones", 3'b110, 7'b0100100);
        waitDigit("t3Tens", 3'b101, 7'b1111001);
        waitDigit("t3Sign", 3'b011, 7'h7F);

        // T4: negative zero
        applyStimulus(5'b1_0000, 1'b1);
        checkOutput("t4Err", 32'(dispIf.err), 32'd0);
        waitDigit("t4Ones", 3'b110, 7'b1000000);
        waitDigit("t4Tens", 3'b101, 7'h7F);
        waitDigit("t4Sign", 3'b011, 7'h7F);

        // T5: inconsistent zeroflag, then corrected
        applyStimulus(5'b0_0011, 1'b1);
        checkOutput("t5ErrSet", 32'(dispIf.err), 32'd1);
        waitDigit("t5OnesE", 3'b110, 7'b0000110);
        waitDigit("t5TensE", 3'b101, 7'h7F);
        waitDigit("t5SignE", 3'b011, 7'h7F);
        applyStimulus(5'b0_0011, 1'b0);
        checkOutput("t5ErrClr", 32'(dispIf.err), 32'd0);
        waitDigit("t5Ones", 3'b110, 7'b0110000);

        // T6: load in the tick cycle (-15), then reset mid-slot
        expSeg[0] = 7'b0010010;
        expSeg[1] = 7'b1111001;
        expSeg[2] = 7'b0111111;
        tickFound = 1'b0;
        for (int i = 0; i < 20 && !tickFound; i++) begin
            @(negedge clk);
            if (mPresc == 3) tickFound = 1'b1;
        end
        checkOutput("t6TickFound", 32'(tickFound), 32'd1);
        dispIf.result   = 5'b1_1111;
        dispIf.zeroflag = 1'b0;
        dispIf.load     = 1'b1;
        @(negedge clk);
        dispIf.load = 1'b0;
        checkOutput("t6GuardAn", 32'(dispIf.an), 32'(3'b111));
        checkOutput("t6GuardSeg", 32'(dispIf.seg), 32'(7'h7F));
        newIdx = mIdx;
        @(negedge clk);
        checkOutput("t6NewAn", 32'(dispIf.an), 32'(expAn(newIdx)));
        checkOutput("t6NewSeg", 32'(dispIf.seg), 32'(expSeg[newIdx]));
        checkOutput("t6Err", 32'(dispIf.err), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6AsyncAn", 32'(dispIf.an), 32'(3'b111));
        checkOutput("t6AsyncSeg", 32'(dispIf.seg), 32'(7'h7F));
        checkOutput("t6AsyncErr", 32'(dispIf.err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            checkOutput("t6ClearedSeg", 32'(dispIf.seg), 32'(7'h7F));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
